// File: rtl/pulse_arbiter.sv
// pulse_arbiter: round-robin arbiter turning four push-button presses into single-cycle step pulses.
// Optional per-channel debounce is enabled by defining PULSE_ARBITER_DEBOUNCE_EN.
module pulse_arbiter #(
    parameter int DEB_CYCLES  = 16,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] pb,
    input  logic       ack,
    output logic       sp,
    output logic [1:0] sp_id,
    output logic [3:0] pending,
    output logic       overrun,
    output logic       timeout
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;
    state_t     state, state_n;
    logic [3:0] s1, s2, lvl, prv, arm, ev, clr;
    logic [1:0] warm, last_grant, winner;
    logic [7:0] cnt;
    logic       expire;

    if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255 || DEB_CYCLES < 1) begin : g_bad_param
        $error("pulse_arbiter: parameter out of range");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pb;
            s2 <= s1;
        end
    end

`ifdef PULSE_ARBITER_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);
    logic [DW-1:0] dcnt [4];
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl <= '0;
            for (int i = 0; i < 4; i++) dcnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == lvl[i]) dcnt[i] <= '0;
                else if (dcnt[i] == DW'(DEB_CYCLES - 1)) begin
                    lvl[i]  <= s2[i];
                    dcnt[i] <= '0;
                end else dcnt[i] <= dcnt[i] + 1'b1;
            end
        end
    end
`else
    assign lvl = s2;
`endif

    // A channel only arms once it has been seen released after the synchronizer has
    // refilled, so a button held through reset cannot produce a press event.
    always_ff @(posedge clk) begin
        if (rst) begin
            warm <= '0;
            prv  <= '0;
            arm  <= '0;
            ev   <= '0;
        end else begin
            warm <= {warm[0], 1'b1};
            prv  <= lvl;
            arm  <= arm | ({4{warm[1]}} & ~lvl & ~s2);
            ev   <= lvl & ~prv & arm;
        end
    end

    always_comb begin
        winner = last_grant;
        for (int i = 4; i >= 1; i--)
            if (pending[last_grant + 2'(i)]) winner = last_grant + 2'(i);
    end

    assign expire  = cnt == 8'(ACK_TIMEOUT - 1);
    assign sp      = state == ISSUE;
    assign timeout = state == WAIT_ACK && !ack && expire;
    assign clr     = sp ? 4'b0001 << sp_id : 4'b0000;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = |pending ? ISSUE : IDLE;
            ISSUE:    state_n = WAIT_ACK;
            WAIT_ACK: state_n = (ack || expire) ? IDLE : WAIT_ACK;
            default:  state_n = IDLE;
        endcase
    end

    // A press landing on the channel being cleared re-sets it without overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sp_id      <= '0;
            last_grant <= 2'd3;
            pending    <= '0;
            overrun    <= 1'b0;
            cnt        <= '0;
        end else begin
            state   <= state_n;
            pending <= (pending & ~clr) | ev;
            overrun <= |(ev & pending & ~clr);
            cnt     <= state == WAIT_ACK ? cnt + 8'd1 : 8'd0;
            if (state == IDLE && |pending) begin
                sp_id      <= winner;
                last_grant <= winner;
            end
        end
    end
endmodule

// File: tb/tb_pulse_arbiter.sv
// tb_pulse_arbiter: directed stimulus with a scoreboard queue of expected step pulses.
module tb_pulse_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] pb  = 4'b0000;
    logic       ack = 1'b0;
    logic       sp, overrun, timeout;
    logic [1:0] sp_id;
    logic [3:0] pending;

    pulse_arbiter dut (
        .clk(clk), .rst(rst), .pb(pb), .ack(ack), .sp(sp), .sp_id(sp_id),
        .pending(pending), .overrun(overrun), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] id; int cyc; } exp_t;
    exp_t q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every step pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (sp) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sp: got sp_id=%0d at cycle %0d, expected no pulse", sp_id, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sp_id", int'(sp_id), int'(e.id));
                chk("sp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        tick(n);
        rst = 1'b0;
        tick(3);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_sp"}, int'(sp), 0);
        chk({tag, "_sp_id"}, int'(sp_id), 0);
        chk({tag, "_pending"}, int'(pending), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
        chk({tag, "_timeout"}, int'(timeout), 0);
    endtask

    initial begin
        int c, d, tcyc, ocnt, ocyc;
        // reset state
        tick(3);
        check_idle_outputs("reset");
        rst = 1'b0;
        tick(3);

        // single press on channel 0, ack tied high
        ack = 1'b1;
        c = cyc;
        pb = 4'b0001;
        q.push_back('{2'd0, c + 5});
        tick(20);
        pb = 4'b0000;
        tick(6);
        chk("single_pending", int'(pending), 0);

        // all four channels together, served 0,1,2,3
        do_reset(2);
        c = cyc;
        pb = 4'b1111;
        for (int i = 0; i < 4; i++) q.push_back('{2'(i), c + 5 + 3 * i});
        tick(20);
        pb = 4'b0000;
        chk("rr_pending", int'(pending), 0);
        tick(4);

        // no ack: grant on channel 2 then timeout
        do_reset(2);
        ack = 1'b0;
        c = cyc;
        pb = 4'b0100;
        q.push_back('{2'd2, c + 5});
        tick(3);
        pb = 4'b0000;
        tcyc = -1;
        for (int i = 0; i < 300 && tcyc < 0; i++) begin
            tick(1);
            if (timeout) tcyc = cyc;
        end
        chk("timeout_cycle", tcyc, c + 5 + 255);
        tick(1);
        chk("timeout_one_cycle", int'(timeout), 0);
        tick(20);
        chk("timeout_pending", int'(pending), 0);

        // overrun on channel 1 while channel 0 holds the consumer
        do_reset(2);
        ack = 1'b0;
        c = cyc;
        pb = 4'b0001;
        q.push_back('{2'd0, c + 5});
        tick(6);
        pb = 4'b0011;
        tick(3);
        pb = 4'b0001;
        tick(4);
        d = cyc;
        pb = 4'b0011;
        ocnt = 0;
        ocyc = -1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (overrun) begin
                ocnt++;
                ocyc = cyc;
            end
        end
        chk("overrun_count", ocnt, 1);
        chk("overrun_cycle", ocyc, d + 4);
        chk("overrun_pending", int'(pending), 4'b0010);
        ack = 1'b1;
        q.push_back('{2'd1, cyc + 2});
        tick(8);
        chk("overrun_drain", int'(pending), 0);
        pb = 4'b0000;
        tick(4);

        // reset mid-grant with channel 3 held
        do_reset(2);
        ack = 1'b0;
        c = cyc;
        pb = 4'b1000;
        q.push_back('{2'd3, c + 5});
        tick(8);
        rst = 1'b1;
        tick(2);
        check_idle_outputs("midreset");
        rst = 1'b0;
        tick(30);
        chk("held_pending", int'(pending), 0);
        pb = 4'b0000;
        tick(5);
        ack = 1'b1;
        c = cyc;
        pb = 4'b1000;
        q.push_back('{2'd3, c + 5});
        tick(10);
        chk("repress_pending", int'(pending), 0);
        pb = 4'b0000;
        tick(4);

        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion before 200000");
        $fatal(1);
    end
endmodule
